// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared types and helpers for the handshake stream blocks
package hs_pkg;

   typedef enum logic {ACC, HOLD} upsz_state_t;

   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hs_out_reg.sv
// rtl/hs_out_reg.sv - registered valid/ready output slice: load, hold while stalled, clear on take
module hs_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         free_o,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   assign free_o  = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   // Payload only changes on load, so it stays stable across any stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/hs_width_upsizer.sv
// rtl/hs_width_upsizer.sv - packs RATIO narrow beats into one wide word with keep and early-close
module hs_width_upsizer
   import hs_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int RATIO  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_i,
   input  logic [DATA_W-1:0]        data_i,
   input  logic                     last_i,
   output logic                     ready_o,
   output logic                     valid_o,
   output logic [DATA_W*RATIO-1:0]  data_o,
   output logic [RATIO-1:0]         keep_o,
   output logic                     last_o,
   input  logic                     ready_i
);

   localparam int CNT_W = clog2_min1(RATIO);
   localparam int OUT_W = DATA_W * RATIO;
   localparam int PAY_W = OUT_W + RATIO + 1;

   upsz_state_t        state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [OUT_W-1:0]   acc_data_q;
   logic [RATIO-1:0]   acc_keep_q;
   logic               acc_last_q;
   logic               ready_q;

   logic [OUT_W-1:0]   lane_data_d;
   logic [RATIO-1:0]   lane_keep_d;
   logic               accept;
   logic               complete;
   logic               out_free;
   logic               load;
   logic [PAY_W-1:0]   load_word;
   logic [PAY_W-1:0]   out_word;

   assign ready_o  = ready_q;
   assign accept   = valid_i && ready_q;
   assign complete = accept && ((cnt_q == CNT_W'(RATIO - 1)) || last_i);

   always_comb begin
      lane_data_d = acc_data_q;
      lane_keep_d = acc_keep_q;
      for (int k = 0; k < RATIO; k++) begin
         if (k == int'(cnt_q)) begin
            lane_data_d[k*DATA_W +: DATA_W] = data_i;
            lane_keep_d[k]                  = 1'b1;
         end
      end
   end

   // In HOLD the parked word drains first; in ACC a completing beat bypasses the accumulator.
   always_comb begin
      load      = 1'b0;
      load_word = {lane_data_d, lane_keep_d, last_i};
      if (state_q == HOLD) begin
         load      = out_free;
         load_word = {acc_data_q, acc_keep_q, acc_last_q};
      end else begin
         load      = complete && out_free;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ACC;
         cnt_q      <= '0;
         acc_data_q <= '0;
         acc_keep_q <= '0;
         acc_last_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               ready_q <= 1'b1;
               if (accept) begin
                  if (complete) begin
                     cnt_q <= '0;
                     if (out_free) begin
                        acc_data_q <= '0;
                        acc_keep_q <= '0;
                        acc_last_q <= 1'b0;
                     end else begin
                        acc_data_q <= lane_data_d;
                        acc_keep_q <= lane_keep_d;
                        acc_last_q <= last_i;
                        state_q    <= HOLD;
                        ready_q    <= 1'b0;
                     end
                  end else begin
                     acc_data_q <= lane_data_d;
                     acc_keep_q <= lane_keep_d;
                     cnt_q      <= cnt_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (out_free) begin
                  acc_data_q <= '0;
                  acc_keep_q <= '0;
                  acc_last_q <= 1'b0;
                  state_q    <= ACC;
                  ready_q    <= 1'b1;
               end
            end
            default: state_q <= ACC;
         endcase
      end
   end

   hs_out_reg #(.W(PAY_W)) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .data_i  (load_word),
      .ready_i (ready_i),
      .free_o  (out_free),
      .valid_o (valid_o),
      .data_o  (out_word)
   );

   assign data_o = out_word[PAY_W-1 -: OUT_W];
   assign keep_o = out_word[RATIO:1];
   assign last_o = out_word[0];

endmodule
